// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v position counters with sync, display-enable,
// line/frame strobes and a frame counter, all registered and aligned to the position.
module video_timing_gen #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit H_SYNC_POLARITY = 1'b0,
  parameter bit V_SYNC_POLARITY = 1'b0,
  parameter int CNT_W           = 11,
  parameter int FRAME_W         = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable_i,
  output logic [CNT_W-1:0]   h_pos_o,
  output logic [CNT_W-1:0]   v_pos_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_count_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_width
    $error("video_timing_gen: every visible/porch/sync width must be at least 1");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  // Window bounds are one bit wider so an end bound equal to 2^CNT_W still fits.
  localparam logic [CNT_W:0]   H_LAST = (CNT_W+1)'(H_TOTAL - 1);
  localparam logic [CNT_W:0]   V_LAST = (CNT_W+1)'(V_TOTAL - 1);
  localparam logic [CNT_W:0]   H_VIS  = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0]   V_VIS  = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0]   HS_BEG = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0]   HS_END = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0]   VS_BEG = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0]   VS_END = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] H_RST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_RST  = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic [CNT_W:0]   h_ext, v_ext;
  logic             h_wrap, frame_nxt, de_nxt, hact_nxt, vact_nxt;
  logic             started;

  // Decode the next position so every registered output lines up with it.
  always_comb begin
    h_wrap = ({1'b0, h_pos_o} == H_LAST);
    h_nxt  = h_wrap ? '0 : h_pos_o + 1'b1;
    v_nxt  = v_pos_o;
    if (h_wrap) begin
      v_nxt = ({1'b0, v_pos_o} == V_LAST) ? '0 : v_pos_o + 1'b1;
    end
    h_ext     = {1'b0, h_nxt};
    v_ext     = {1'b0, v_nxt};
    de_nxt    = (h_ext < H_VIS) && (v_ext < V_VIS);
    hact_nxt  = (h_ext >= HS_BEG) && (h_ext < HS_END);
    vact_nxt  = (v_ext >= VS_BEG) && (v_ext < VS_END);
    frame_nxt = h_wrap && (v_nxt == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_pos_o       <= H_RST;
      v_pos_o       <= V_RST;
      hsync_o       <= ~H_SYNC_POLARITY;
      vsync_o       <= ~V_SYNC_POLARITY;
      de_o          <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      frame_count_o <= '0;
      started       <= 1'b0;
    end else if (enable_i) begin
      h_pos_o       <= h_nxt;
      v_pos_o       <= v_nxt;
      hsync_o       <= hact_nxt ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
      vsync_o       <= vact_nxt ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
      de_o          <= de_nxt;
      line_start_o  <= h_wrap;
      frame_start_o <= frame_nxt;
      // The first frame after reset is frame 0; later frames count up.
      if (frame_nxt) begin
        if (started) frame_count_o <= frame_count_o + 1'b1;
        else         started       <= 1'b1;
      end
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised VGA-style raster timing generator: horizontal/vertical counters, sync pulses of configurable polarity, display enable, line/frame strobes and a running frame counter.
- Feeds the pixel pipeline and video output stage of xosera_main.
- Generalises the fixed 640x480 timing and the bench-side frame counting into one synthesizable, mode-configurable block.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POLARITY, 0, active level of hsync_o
V_SYNC_POLARITY, 0, active level of vsync_o
CNT_W, 11, width of h/v position counters
FRAME_W, 16, width of frame counter

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
enable_i  in  1  advance raster one pixel per cycle when 1
h_pos_o  out  CNT_W  current horizontal position
v_pos_o  out  CNT_W  current vertical position
hsync_o  out  1  horizontal sync, level per H_SYNC_POLARITY
vsync_o  out  1  vertical sync, level per V_SYNC_POLARITY
de_o  out  1  display enable (visible pixel)
line_start_o  out  1  one-cycle strobe at h_pos 0
frame_start_o  out  1  one-cycle strobe at (0,0)
frame_count_o  out  FRAME_W  index of current frame

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n).
- H_TOTAL = sum of H_* widths; V_TOTAL = sum of V_* widths. Every width >= 1, H_TOTAL and V_TOTAL <= 2^CNT_W; otherwise elaboration error.
- All outputs registered; every output is consistent with the h_pos_o/v_pos_o presented in the same cycle (no skew between position and decoded signals).
- Reset (asserted any time, incl. mid-frame): h_pos_o = H_TOTAL-1, v_pos_o = V_TOTAL-1, hsync_o = ~H_SYNC_POLARITY, vsync_o = ~V_SYNC_POLARITY, de_o = 0, strobes 0, frame_count_o = 0, internal started flag = 0.
- Each edge with enable_i = 1: h = (h == H_TOTAL-1) ? 0 : h+1; on h wrap, v = (v == V_TOTAL-1) ? 0 : v+1; otherwise v holds.
- enable_i = 0: positions, sync, de and frame_count_o hold; line_start_o and frame_start_o forced 0 (strobes never repeat while stalled).
- Decode, at position (h,v):
  - de_o = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hsync active iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync active iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, on the whole line including h = 0.
  - line_start_o = 1 for the single enabled cycle on which h becomes 0.
  - frame_start_o = 1 for the single enabled cycle on which (h,v) becomes (0,0).
- Frame counter:
  - First frame_start after reset sets started = 1 and leaves frame_count_o at 0.
  - Every later frame_start increments frame_count_o modulo 2^FRAME_W; it updates in the same cycle as the strobe.
- Widths: counters compare at CNT_W bits; no overflow past H_TOTAL-1 / V_TOTAL-1 is ever produced.

Test Plan:
- Small mode H=8/2/2/2 (H_TOTAL 14), V=4/1/1/1 (V_TOTAL 7), polarities 0; release reset, enable=1 -> first cycle (0,0) with frame_start=1, line_start=1, de=1, frame_count=0; de high for h 0..7 on v 0..3; hsync=0 exactly at h 10..11; vsync=0 on all of line 5.
- Same mode, run 3 full frames (294 cycles) -> frame_start pulses every 98 cycles; frame_count reads 0,1,2; line_start every 14 cycles.
- Stall: drop enable_i for 5 cycles at (13,6) -> outputs hold at (13,6), no strobes; re-enable -> (0,0) with a single frame_start, frame_count increments once.
- Polarity: H_SYNC_POLARITY=1, V_SYNC_POLARITY=1 -> idle levels 0 after reset, active 1 in the sync windows; default 640x480 gives a 96-cycle hsync per 800-cycle line and a 2-line vsync per 525 lines.
- Reset mid-frame at (5,2) -> next cycle (13,6), syncs inactive, frame_count=0; first frame_start after release leaves frame_count 0.
- Wrap: FRAME_W=2, run 5 frames -> frame_count sequence 0,1,2,3,0.
